// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences IF/ID/EXE/MEM/WB,
// drives the datapath strobes and counts retired instructions (one PCWre pulse each).
`timescale 1ns/1ps
module multicycle_ctrl #(
    parameter int          CNT_W   = 32,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWre,
    output logic [1:0]       PCSrc,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             mRD,
    output logic             mWR,
    output logic             RegWre,
    output logic             RegDst,
    output logic             ALUSrcB,
    output logic             ExtSel,
    output logic             DBDataSrc,
    output logic [2:0]       ALUOp,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);
    localparam logic [3:0] S_IF     = 4'd0;
    localparam logic [3:0] S_ID     = 4'd1;
    localparam logic [3:0] S_EXE_LS = 4'd2;
    localparam logic [3:0] S_MEM    = 4'd3;
    localparam logic [3:0] S_WB_LD  = 4'd4;
    localparam logic [3:0] S_EXE_BR = 4'd5;
    localparam logic [3:0] S_EXE_AL = 4'd6;
    localparam logic [3:0] S_WB_AL  = 4'd7;
    localparam logic [3:0] S_HALT   = 4'd8;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [3:0]       state_reg, state_next;
    logic             illegal_reg, illegal_set;
    logic [CNT_W-1:0] retired_reg;
    logic             is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_j, is_halt;
    logic             funct_ok;
    logic [2:0]       r_aluop;

    assign is_r    = (op == OP_R);
    assign is_addi = (op == OP_ADDI);
    assign is_ori  = (op == OP_ORI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_j    = (op == OP_J);
    assign is_halt = (op == HALT_OP);

    always_comb begin
        funct_ok = 1'b1;
        r_aluop  = 3'b000;
        case (funct)
            6'b100000: r_aluop = 3'b000;
            6'b100010: r_aluop = 3'b001;
            6'b100100: r_aluop = 3'b010;
            6'b100101: r_aluop = 3'b011;
            6'b101010: r_aluop = 3'b100;
            default:   funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        PCWre       = 1'b0;
        PCSrc       = 2'b00;
        IRWre       = 1'b0;
        InsMemRW    = 1'b0;
        mRD         = 1'b0;
        mWR         = 1'b0;
        RegWre      = 1'b0;
        RegDst      = 1'b0;
        ALUSrcB     = 1'b0;
        ExtSel      = 1'b0;
        DBDataSrc   = 1'b0;
        ALUOp       = 3'b000;
        illegal_set = 1'b0;
        state_next  = state_reg;
        case (state_reg)
            S_IF: begin
                InsMemRW = 1'b1;
                IRWre    = mem_ready;
                if (mem_ready) state_next = S_ID;
            end
            S_ID: begin
                if (is_j) begin
                    PCWre      = 1'b1;
                    PCSrc      = 2'b10;
                    state_next = S_IF;
                end else if (is_beq) begin
                    state_next = S_EXE_BR;
                end else if (is_lw || is_sw) begin
                    state_next = S_EXE_LS;
                end else if ((is_r && funct_ok) || is_addi || is_ori) begin
                    state_next = S_EXE_AL;
                end else if (is_halt) begin
                    state_next = S_HALT;
                end else begin
                    state_next  = S_HALT;
                    illegal_set = 1'b1;
                end
            end
            S_EXE_AL: begin
                ALUSrcB    = is_addi || is_ori;
                ExtSel     = is_addi;
                ALUOp      = is_r ? r_aluop : (is_ori ? 3'b011 : 3'b000);
                state_next = S_WB_AL;
            end
            S_WB_AL: begin
                RegWre     = 1'b1;
                RegDst     = is_r;
                PCWre      = 1'b1;
                state_next = S_IF;
            end
            S_EXE_BR: begin
                ALUOp      = 3'b001;
                PCWre      = 1'b1;
                PCSrc      = zero ? 2'b01 : 2'b00;
                ExtSel     = 1'b1;
                state_next = S_IF;
            end
            S_EXE_LS: begin
                ALUSrcB    = 1'b1;
                ExtSel     = 1'b1;
                state_next = S_MEM;
            end
            S_MEM: begin
                mRD = !is_sw;
                mWR = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        PCWre      = 1'b1;
                        state_next = S_IF;
                    end else begin
                        state_next = S_WB_LD;
                    end
                end
            end
            S_WB_LD: begin
                RegWre     = 1'b1;
                DBDataSrc  = 1'b1;
                PCWre      = 1'b1;
                state_next = S_IF;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IF;
        endcase
        // Reset silences every strobe in the cycle it is asserted, whatever the state.
        if (Reset) begin
            PCWre       = 1'b0;
            PCSrc       = 2'b00;
            IRWre       = 1'b0;
            InsMemRW    = 1'b0;
            mRD         = 1'b0;
            mWR         = 1'b0;
            RegWre      = 1'b0;
            RegDst      = 1'b0;
            ALUSrcB     = 1'b0;
            ExtSel      = 1'b0;
            DBDataSrc   = 1'b0;
            ALUOp       = 3'b000;
            illegal_set = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg   <= S_IF;
            illegal_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (illegal_set) illegal_reg <= 1'b1;
            if (PCWre) retired_reg <= retired_reg + 1'b1;
        end
    end

    assign state      = state_reg;
    assign halted     = (state_reg == S_HALT);
    assign illegal_op = illegal_reg;
    assign retired    = retired_reg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction streams checked
// against an instruction-level model (latency, strobe counts, branch/ALU selections).
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    logic        CLK = 1'b0;
    logic        Reset;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        PCWre, IRWre, InsMemRW, mRD, mWR, RegWre, RegDst, ALUSrcB, ExtSel, DBDataSrc;
    logic [1:0]  PCSrc;
    logic [2:0]  ALUOp;
    logic [3:0]  state;
    logic        halted, illegal_op;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    int st_log[$];

    always #5 CLK = ~CLK;

    multicycle_ctrl #(.CNT_W(32), .HALT_OP(6'b111111)) dut (
        .CLK(CLK), .Reset(Reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW), .mRD(mRD), .mWR(mWR),
        .RegWre(RegWre), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
        .DBDataSrc(DBDataSrc), .ALUOp(ALUOp), .state(state), .halted(halted),
        .illegal_op(illegal_op), .retired(retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b001;
            6'b100100: return 3'b010;
            6'b100101: return 3'b011;
            6'b101010: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    // One legal instruction from IF back to IF; wif/wmem = not-ready cycles in IF/MEM.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int wif, input int wmem);
        bit is_j, is_br, is_lw, is_sw, is_r, is_addi, is_ori, ls, wr_reg;
        int total, pc_cnt, pc_at, reg_cnt, rd_cnt, wr_cnt, ir_cnt, im_cnt;
        logic [1:0]  pcsrc_seen, pcsrc_exp;
        logic [2:0]  alu_seen, alu_exp;
        logic        regdst_seen, db_seen, srcb_seen, ext_seen;
        logic [31:0] ret0;
        is_j = (o == 6'b000010); is_br = (o == 6'b000100);
        is_lw = (o == 6'b100011); is_sw = (o == 6'b101011);
        is_r = (o == 6'b000000); is_addi = (o == 6'b001000); is_ori = (o == 6'b001101);
        ls = is_lw || is_sw;
        wr_reg = is_r || is_addi || is_ori || is_lw;
        total = wif + (is_j ? 2 : is_br ? 3 : is_lw ? 5 : 4) + (ls ? wmem : 0);
        pc_cnt = 0; pc_at = -1; reg_cnt = 0; rd_cnt = 0; wr_cnt = 0; ir_cnt = 0; im_cnt = 0;
        pcsrc_seen = 2'b11; alu_seen = 3'b111; regdst_seen = 1'bx; db_seen = 1'bx;
        srcb_seen = 1'bx; ext_seen = 1'bx;
        ret0 = retired;
        st_log.delete();
        for (int c = 0; c < total; c++) begin
            @(negedge CLK);
            op = o; funct = f; zero = z;
            if (c < wif || (ls && c >= wif + 3 && c < wif + 3 + wmem)) mem_ready = 1'b0;
            else if (c == wif || (ls && c == wif + 3 + wmem)) mem_ready = 1'b1;
            else mem_ready = 1'($urandom_range(0, 1));
            #1;
            st_log.push_back(int'(state));
            if (PCWre) begin pc_cnt++; pc_at = c; pcsrc_seen = PCSrc; end
            if (RegWre) begin reg_cnt++; regdst_seen = RegDst; db_seen = DBDataSrc; end
            if (mRD) rd_cnt++;
            if (mWR) wr_cnt++;
            if (IRWre) ir_cnt++;
            if (InsMemRW) im_cnt++;
            if (c == wif + 2) begin
                alu_seen = ALUOp; srcb_seen = ALUSrcB; ext_seen = ExtSel;
            end
        end
        @(posedge CLK); #1;
        pcsrc_exp = is_j ? 2'b10 : (is_br && z) ? 2'b01 : 2'b00;
        chk("back_to_if", 32'(state), 32'd0);
        chk("retired_inc", retired, ret0 + 32'd1);
        chk("pcwre_once", 32'(pc_cnt), 32'd1);
        chk("pcwre_last_cycle", 32'(pc_at), 32'(total - 1));
        chk("pcsrc", 32'(pcsrc_seen), 32'(pcsrc_exp));
        chk("regwre_count", 32'(reg_cnt), wr_reg ? 32'd1 : 32'd0);
        chk("mrd_cycles", 32'(rd_cnt), is_lw ? 32'(wmem + 1) : 32'd0);
        chk("mwr_cycles", 32'(wr_cnt), is_sw ? 32'(wmem + 1) : 32'd0);
        chk("irwre_count", 32'(ir_cnt), 32'd1);
        chk("insmemrw_cycles", 32'(im_cnt), 32'(wif + 1));
        if (wr_reg) begin
            chk("regdst", 32'(regdst_seen), is_r ? 32'd1 : 32'd0);
            chk("dbdatasrc", 32'(db_seen), is_lw ? 32'd1 : 32'd0);
        end
        if (!is_j) begin
            alu_exp = is_br ? 3'b001 : is_ori ? 3'b011 : is_r ? funct_alu(f) : 3'b000;
            chk("aluop", 32'(alu_seen), 32'(alu_exp));
            chk("alusrcb", 32'(srcb_seen), (ls || is_addi || is_ori) ? 32'd1 : 32'd0);
            chk("extsel", 32'(ext_seen), (is_br || ls || is_addi) ? 32'd1 : 32'd0);
        end
        $display("txn op=%b funct=%b zero=%0d wif=%0d wmem=%0d cycles=%0d retired=%0d",
                 o, f, z, wif, wmem, total, retired);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b1; mem_ready = 1'b0;
        #1;
        chk("reset_pcwre", 32'(PCWre), 32'd0);
        chk("reset_mwr", 32'(mWR), 32'd0);
        chk("reset_insmemrw", 32'(InsMemRW), 32'd0);
        @(posedge CLK); #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_retired", retired, 32'd0);
        chk("reset_illegal", 32'(illegal_op), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] functs[5];
        int exp_states[$];
        int hold_pc;
        ops = '{6'b000000, 6'b001000, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        Reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge CLK);
        do_reset();

        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        exp_states = '{0, 1, 6, 7};
        chk("radd_states", (st_log == exp_states) ? 32'd1 : 32'd0, 32'd1);
        chk("radd_retired", retired, 32'd1);

        run_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
        exp_states = '{0, 1, 2, 3, 3, 3, 3, 4};
        chk("lw_wait_states", (st_log == exp_states) ? 32'd1 : 32'd0, 32'd1);

        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
        exp_states = '{0, 1};
        chk("j_states", (st_log == exp_states) ? 32'd1 : 32'd0, 32'd1);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_instr(ops[$urandom_range(0, 6)], functs[$urandom_range(0, 4)],
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
        end

        // sw stalled in MEM, then reset mid-wait
        @(negedge CLK); op = 6'b101011; mem_ready = 1'b1;
        @(negedge CLK); mem_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK); #1;
        chk("sw_mem_state", 32'(state), 32'd3);
        chk("sw_mem_mwr", 32'(mWR), 32'd1);
        do_reset();

        // Unknown opcode: halts sticky-illegal, no PC writes
        hold_pc = 0;
        @(negedge CLK); op = 6'b110011; mem_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK); mem_ready = 1'($urandom_range(0, 1)); #1;
            if (PCWre) hold_pc++;
        end
        chk("ill_state", 32'(state), 32'd8);
        chk("ill_halted", 32'(halted), 32'd1);
        chk("ill_flag", 32'(illegal_op), 32'd1);
        chk("ill_no_pcwre", 32'(hold_pc), 32'd0);
        chk("ill_retired", retired, 32'd0);
        $display("txn op=110011 illegal halt state=%0d illegal_op=%0d", state, illegal_op);
        do_reset();

        // Illegal R-type funct also halts with the flag
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        @(negedge CLK); op = 6'b000000; funct = 6'b000111; mem_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK); #1;
        chk("badfunct_state", 32'(state), 32'd8);
        chk("badfunct_flag", 32'(illegal_op), 32'd1);
        do_reset();

        // HALT_OP halts without the illegal flag
        @(negedge CLK); op = 6'b111111; mem_ready = 1'b1;
        repeat (4) @(negedge CLK);
        #1;
        chk("halt_state", 32'(state), 32'd8);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_no_illegal", 32'(illegal_op), 32'd0);
        chk("halt_pcsrc_idle", 32'(PCWre), 32'd0);
        $display("txn op=111111 halt state=%0d halted=%0d", state, halted);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
